// File: rtl/pixel_gen_pkg.sv
// pixel_gen_pkg
// Shared constants and helpers for the pixel generators:
//   - visible display size and the row used to derive the once-per-frame tick
//   - colour constants, {R[3:0],G[3:0],B[3:0]}
//   - RUN/PAUSED state encoding
//   - span test and single-axis bounce step used by bounce_pixel_gen
package pixel_gen_pkg;

  localparam int H_DISP         = 640;
  localparam int V_DISP         = 480;
  localparam int FRAME_TICK_ROW = 481;

  localparam logic [11:0] COLOR_BLACK     = 12'h000;
  localparam logic [11:0] COLOR_SQ_RUN    = 12'hF00;
  localparam logic [11:0] COLOR_SQ_PAUSED = 12'hFF0;
  localparam logic [11:0] COLOR_BORDER    = 12'hFFF;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_PAUSED = 1'b1
  } state_e;

  // True when start <= p < start+size. Evaluated in 11 bits so that a square
  // near the right/bottom edge cannot wrap the upper bound.
  function automatic logic in_span(input logic [9:0] p, input logic [9:0] start,
                                   input int unsigned size);
    logic [10:0] upper;
    upper = {1'b0, start} + 11'(size);
    return ({1'b0, p} >= {1'b0, start}) && ({1'b0, p} < upper);
  endfunction

  // One frame of motion on one axis. Returns {new_dir, new_pos}.
  // Moving forward clamps at limit and reverses in the same update; moving
  // back only subtracts when pos > speed, otherwise lands on 0 and reverses,
  // so the position never wraps below zero.
  function automatic logic [10:0] axis_step(input logic [9:0] pos, input logic dir,
                                            input logic [9:0] limit,
                                            input logic [9:0] speed);
    logic [10:0] sum;
    logic [9:0]  npos;
    logic        ndir;
    sum  = {1'b0, pos} + {1'b0, speed};
    npos = pos;
    ndir = dir;
    if (dir) begin
      if (sum >= {1'b0, limit}) begin
        npos = limit;
        ndir = 1'b0;
      end else begin
        npos = sum[9:0];
      end
    end else begin
      if (pos > speed) begin
        npos = pos - speed;
      end else begin
        npos = '0;
        ndir = 1'b1;
      end
    end
    return {ndir, npos};
  endfunction

endpackage

// File: rtl/bounce_pixel_gen_if.sv
// bounce_pixel_gen_if
// Pixel-stream bundle between the VGA timing side and the pixel generator.
//   p_tick   : one-cycle 25 MHz pixel strobe
//   video_on : (x,y) inside the 640x480 display area
//   x, y     : current pixel column / row
//   bg_color : background colour
//   rgb      : registered pixel colour (generator output)
//   paused   : generator is in PAUSED (generator output)
// master = timing/test side, slave = pixel generator.
interface bounce_pixel_gen_if;
  logic        p_tick;
  logic        video_on;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [11:0] bg_color;
  logic [11:0] rgb;
  logic        paused;

  modport master (output p_tick, video_on, x, y, bg_color, input rgb, paused);
  modport slave  (input p_tick, video_on, x, y, bg_color, output rgb, paused);
endinterface

// File: rtl/btn_sync_edge.sv
// btn_sync_edge
// Two-flop synchroniser for a raw asynchronous input followed by a rising
// edge detector. No debounce: every clean rising edge after synchronisation
// gives one pulse.
//   clk   : sampling clock
//   reset : asynchronous, active-high; clears all flops
//   din   : raw asynchronous input
//   rise  : one-cycle pulse on a synchronised 0->1 transition
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/bounce_pixel_gen.sv
// bounce_pixel_gen
// Draws a square that bounces around the 640x480 display, moving once per
// frame. A pause pushbutton toggles between moving and frozen; the square is
// red while moving and yellow while frozen.
//   clk_100MHz : system clock
//   reset      : asynchronous, active-high
//   btn_pause  : raw pause pushbutton (synchronised internally)
//   pix        : pixel stream (slave): p_tick, video_on, x, y, bg_color in;
//                rgb, paused out
// Optional build macro BOUNCE_PIXEL_GEN_BORDER_EN: draws a white one-pixel
// frame around the display area (square still drawn on top of it).
//
// state  | meaning
// -------+-------------------------------------------------
// RUN    | square advances by SQ_SPEED per axis each frame
// PAUSED | square frozen, drawn in yellow
module bounce_pixel_gen
  import pixel_gen_pkg::*;
#(
  parameter int SQ_SIZE  = 16,
  parameter int SQ_SPEED = 2
) (
  input  logic                clk_100MHz,
  input  logic                reset,
  input  logic                btn_pause,
  bounce_pixel_gen_if.slave   pix
);

  localparam logic [9:0] X_LIMIT = 10'(H_DISP - SQ_SIZE);
  localparam logic [9:0] Y_LIMIT = 10'(V_DISP - SQ_SIZE);
  localparam logic [9:0] X_START = 10'((H_DISP - SQ_SIZE) / 2);
  localparam logic [9:0] Y_START = 10'((V_DISP - SQ_SIZE) / 2);
  localparam logic [9:0] SPEED   = 10'(SQ_SPEED);

  state_e      state_q, state_d;
  logic [9:0]  sq_x_q, sq_x_d;
  logic [9:0]  sq_y_q, sq_y_d;
  logic        dir_x_q, dir_x_d;
  logic        dir_y_q, dir_y_d;
  logic [11:0] rgb_q, rgb_d;
  logic        paused_q, paused_d;

  logic        btn_rise;
  logic        frame_tick;
  logic        sq_hit;
  logic [10:0] x_next;
  logic [10:0] y_next;
  logic [11:0] pix_color;

  btn_sync_edge u_btn_sync_edge (
    .clk   (clk_100MHz),
    .reset (reset),
    .din   (btn_pause),
    .rise  (btn_rise)
  );

  // Row 481 is in vertical blanking, so the square never moves mid-picture.
  assign frame_tick = pix.p_tick && (pix.x == 10'd0) && (pix.y == 10'(FRAME_TICK_ROW));

  assign x_next = axis_step(sq_x_q, dir_x_q, X_LIMIT, SPEED);
  assign y_next = axis_step(sq_y_q, dir_y_q, Y_LIMIT, SPEED);

  // Next state and motion. Motion looks at state_q, so a button edge that
  // lands on the frame tick only takes effect from the following frame.
  always_comb begin
    state_d  = state_q;
    sq_x_d   = sq_x_q;
    sq_y_d   = sq_y_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;

    if (btn_rise) begin
      state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
    end

    if (frame_tick && (state_q == ST_RUN)) begin
      sq_x_d  = x_next[9:0];
      dir_x_d = x_next[10];
      sq_y_d  = y_next[9:0];
      dir_y_d = y_next[10];
    end

    paused_d = (state_d == ST_PAUSED);
  end

  assign sq_hit = in_span(pix.x, sq_x_q, SQ_SIZE) && in_span(pix.y, sq_y_q, SQ_SIZE);

  always_comb begin
    pix_color = pix.bg_color;
    if (!pix.video_on) begin
      pix_color = COLOR_BLACK;
    end else if (sq_hit) begin
      pix_color = (state_q == ST_PAUSED) ? COLOR_SQ_PAUSED : COLOR_SQ_RUN;
    end
`ifdef BOUNCE_PIXEL_GEN_BORDER_EN
    else if ((pix.x == 10'd0) || (pix.x == 10'(H_DISP - 1)) ||
             (pix.y == 10'd0) || (pix.y == 10'(V_DISP - 1))) begin
      pix_color = COLOR_BORDER;
    end
`else
    else begin
      pix_color = pix.bg_color;
    end
`endif
  end

  // Output colour only advances on the pixel strobe so the DAC sees a stable
  // value for the whole 25 MHz pixel period.
  always_comb begin
    rgb_d = rgb_q;
    if (pix.p_tick) begin
      rgb_d = pix_color;
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q  <= ST_RUN;
      sq_x_q   <= X_START;
      sq_y_q   <= Y_START;
      dir_x_q  <= 1'b1;
      dir_y_q  <= 1'b1;
      rgb_q    <= COLOR_BLACK;
      paused_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sq_x_q   <= sq_x_d;
      sq_y_q   <= sq_y_d;
      dir_x_q  <= dir_x_d;
      dir_y_q  <= dir_y_d;
      rgb_q    <= rgb_d;
      paused_q <= paused_d;
    end
  end

  assign pix.rgb    = rgb_q;
  assign pix.paused = paused_q;

endmodule

// File: doc/bounce_pixel_gen.md
BOUNCE_PIXEL_GEN -- requirements
Module: bounce_pixel_gen

Interface
- REQ-001 SHALL have parameter SQ_SIZE, 16, square side in pixels.
- REQ-002 SHALL have parameter SQ_SPEED, 2, pixels moved per frame per axis.
- REQ-003 SHALL have port clk_100MHz  input  1  system clock, 100 MHz.
- REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
- REQ-005 SHALL have port p_tick  input  1  one-cycle 25 MHz pixel strobe from the VGA timing block.
- REQ-006 SHALL have port video_on  input  1  high while (x,y) is inside the 640x480 display area.
- REQ-007 SHALL have ports x and y  input  10 each  current pixel column and row counters.
- REQ-008 SHALL have port btn_pause  input  1  raw, asynchronous pause pushbutton.
- REQ-009 SHALL have port bg_color  input  12  background colour, {R[3:0],G[3:0],B[3:0]}.
- REQ-010 SHALL have port rgb  output  12  registered pixel colour to the DAC pins.
- REQ-011 SHALL have port paused  output  1  high while the FSM is in PAUSED.

Function
- REQ-012 SHALL generate frame_tick = p_tick && x==0 && y==481, once per frame.
- REQ-013 SHALL hold square position sq_x and sq_y (10 bits each) and direction bits dir_x and dir_y (1 = right or down).
- REQ-014 SHALL update position only on frame_tick while in RUN; it SHALL hold position at all other times.
- REQ-015 SHALL move right by SQ_SPEED; if the result is >= 640-SQ_SIZE (624), it SHALL clamp to 624 and set dir_x=0 in the same update.
- REQ-016 SHALL move left by SQ_SPEED when sq_x > SQ_SPEED; otherwise it SHALL set sq_x=0 and dir_x=1. There SHALL be no unsigned underflow.
- REQ-017 SHALL apply the same rules to Y, with limit 480-SQ_SIZE (464).
- REQ-018 SHALL use FSM states RUN and PAUSED, with RUN after reset.
- REQ-019 SHALL toggle RUN<->PAUSED on each rising edge of the synchronised btn_pause.
- REQ-020 SHALL apply a toggle that coincides with frame_tick after that frame's update; the update uses the pre-toggle state.
- REQ-021 SHALL synchronise btn_pause with two flip-flops and detect the edge on clk_100MHz, with no debounce.
- REQ-022 SHALL define the square hit as sq_x <= x < sq_x+SQ_SIZE and sq_y <= y < sq_y+SQ_SIZE.
- REQ-023 SHALL select colour by priority: video_on low -> 12'h000; square hit -> 12'hF00 (RUN) or 12'hFF0 (PAUSED); otherwise bg_color.
- REQ-024 SHALL register rgb on clk_100MHz only when p_tick is high; rgb SHALL hold between ticks, giving one pixel-tick latency.
- REQ-025 SHALL make paused equal (state==PAUSED), registered.

Reset
- REQ-026 SHALL on reset set rgb=0, paused=0, state=RUN, sq_x=312, sq_y=232, dir_x=1, dir_y=1, and clear the synchroniser flops.
- REQ-027 SHALL, if reset is asserted mid-frame, reach reset values immediately and resume motion at the next frame_tick after release.

Configuration
- REQ-028 SHALL, with macro BOUNCE_PIXEL_GEN_BORDER_EN defined, draw 12'hFFF where x==0, x==639, y==0 or y==479 inside video_on; the square SHALL still have priority over the border.
- REQ-029 SHALL, without BOUNCE_PIXEL_GEN_BORDER_EN, have no border logic; those pixels SHALL show bg_color.

Structure
- REQ-030 SHALL place in shared package pixel_gen_pkg: H_DISP=640, V_DISP=480, FRAME_TICK_ROW=481, the colour constants and the RUN/PAUSED state encoding.
- REQ-031 SHALL implement the synchroniser and edge detector as sub-module btn_sync_edge (ports: clk, reset, din, rise).

Verification
- REQ-032 SHALL check: release reset, first frame_tick -> sq_x=314, sq_y=234; rgb at (312,232) on the preceding frame = 12'hF00.
- REQ-033 SHALL check: force sq_x=622 with dir_x=1, then frame_tick -> sq_x=624, dir_x=0; next frame_tick -> sq_x=622.
- REQ-034 SHALL check: sq_y=1 with dir_y=0, then frame_tick -> sq_y=0, dir_y=1, and no value of 1023 is ever seen.
- REQ-035 SHALL check: pulse btn_pause 200 ns -> paused=1 within 3 clocks; position frozen over 3 frames; square colour 12'hFF0; a second pulse -> motion resumes.
- REQ-036 SHALL check: bg_color=12'h0A5 with video_on=0 -> rgb=12'h000; with video_on=1 and no hit -> rgb=12'h0A5, changing only on p_tick edges.
- REQ-037 SHALL check: with BOUNCE_PIXEL_GEN_BORDER_EN defined, (0,100) -> 12'hFFF; without it, (0,100) -> bg_color.
